// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_ctrl_pkg: state encodings, field select codes and field limits for the time-setting sequencer
package clock_set_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_SET_HOUR, ST_SET_MIN, ST_SET_SEC} state_t;
  localparam logic [1:0] FS_NONE = 2'b00;
  localparam logic [1:0] FS_HOUR = 2'b01;
  localparam logic [1:0] FS_MIN = 2'b10;
  localparam logic [1:0] FS_SEC = 2'b11;
  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: buttons, live counts and counter-control outputs of the time-setting sequencer
interface clock_set_ctrl_if;
  logic tick_1hz;
  logic mode_btn;
  logic inc_btn;
  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic [4:0] cur_hour;
  logic enable_sec;
  logic load_sec;
  logic load_min;
  logic load_hour;
  logic [5:0] data_sec;
  logic [5:0] data_min;
  logic [4:0] data_hour;
  logic commit;
  logic setting;
  logic [1:0] field_sel;
  modport master (
    output tick_1hz, mode_btn, inc_btn, cur_sec, cur_min, cur_hour,
    input enable_sec, load_sec, load_min, load_hour, data_sec, data_min, data_hour, commit, setting, field_sel
  );
  modport slave (
    input tick_1hz, mode_btn, inc_btn, cur_sec, cur_min, cur_hour,
    output enable_sec, load_sec, load_min, load_hour, data_sec, data_min, data_hour, commit, setting, field_sel
  );
endinterface

// File: rtl/clock_set_ctrl_btn_edge.sv
// btn_edge: one-cycle pulse on the rising edge of a synchronised button level
module btn_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic btn_q;
  always_ff @(posedge clock or posedge reset)
    if (reset) btn_q <= 1'b0;
    else btn_q <= btn;
  assign rise = btn & ~btn_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET_HOUR/SET_MIN/SET_SEC sequencer editing shadow time registers for the HH:MM:SS chain
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int TIMEOUT_S = 10,
  parameter int TW = 4
) (
  input logic clock,
  input logic reset,
  clock_set_ctrl_if.slave bus
);
  state_t state, state_d;
  logic mode_rise, inc_rise, setting, tmo_hit, commit_d, commit_q, enable_q;
  logic [TW-1:0] tmo;
  logic [5:0] sh_sec, sh_min;
  logic [4:0] sh_hour;
  btn_edge u_mode (.clock(clock), .reset(reset), .btn(bus.mode_btn), .rise(mode_rise));
  btn_edge u_inc (.clock(clock), .reset(reset), .btn(bus.inc_btn), .rise(inc_rise));
  always_comb begin
    setting = state != ST_RUN;
    tmo_hit = setting && tmo == TW'(TIMEOUT_S);
    state_d = state;
    if (tmo_hit) state_d = ST_RUN;
    else if (mode_rise)
      state_d = state == ST_RUN ? ST_SET_HOUR : state == ST_SET_HOUR ? ST_SET_MIN :
                state == ST_SET_MIN ? ST_SET_SEC : ST_RUN;
    commit_d = setting && state_d == ST_RUN;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= ST_RUN;
    else state <= state_d;
  // inc is only honoured when no mode press shares the cycle
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      enable_q <= 1'b0;
      commit_q <= 1'b0;
      tmo <= '0;
      sh_sec <= '0;
      sh_min <= '0;
      sh_hour <= '0;
    end else begin
      enable_q <= bus.tick_1hz && !setting && !mode_rise;
      commit_q <= commit_d;
      if (!setting || mode_rise || inc_rise) tmo <= '0;
      else if (bus.tick_1hz && !tmo_hit) tmo <= tmo + 1'b1;
      if (!setting && mode_rise) begin
        sh_sec <= bus.cur_sec;
        sh_min <= bus.cur_min;
        sh_hour <= bus.cur_hour;
      end else if (inc_rise && !mode_rise) begin
        if (state == ST_SET_HOUR) sh_hour <= sh_hour >= MAX_HOUR ? '0 : sh_hour + 1'b1;
        if (state == ST_SET_MIN) sh_min <= sh_min >= MAX_MIN ? '0 : sh_min + 1'b1;
        if (state == ST_SET_SEC) sh_sec <= sh_sec >= MAX_SEC ? '0 : sh_sec + 1'b1;
      end
    end
  assign bus.enable_sec = enable_q;
  assign bus.commit = commit_q;
  assign bus.setting = setting;
  assign bus.load_sec = setting | commit_q;
  assign bus.load_min = setting | commit_q;
  assign bus.load_hour = setting | commit_q;
  assign bus.data_sec = sh_sec;
  assign bus.data_min = sh_min;
  assign bus.data_hour = sh_hour;
  assign bus.field_sel = state == ST_SET_HOUR ? FS_HOUR : state == ST_SET_MIN ? FS_MIN :
                         state == ST_SET_SEC ? FS_SEC : FS_NONE;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed checks of the time-setting sequencer with hand-computed expectations
module tb_clock_set_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  clock_set_ctrl_if bus ();
  clock_set_ctrl #(.TIMEOUT_S(10), .TW(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clock);
  endtask
  task automatic press_mode();
    bus.mode_btn = 1'b1;
    cyc();
    bus.mode_btn = 1'b0;
    cyc();
  endtask
  task automatic press_inc();
    bus.inc_btn = 1'b1;
    cyc();
    bus.inc_btn = 1'b0;
    cyc();
  endtask
  task automatic tick();
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    cyc();
  endtask
  initial begin
    bus.tick_1hz = 1'b0;
    bus.mode_btn = 1'b0;
    bus.inc_btn = 1'b0;
    bus.cur_sec = 6'd0;
    bus.cur_min = 6'd0;
    bus.cur_hour = 5'd0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("rst_setting", bus.setting, 0);
    chk("rst_field", bus.field_sel, 0);
    chk("rst_load", {bus.load_hour, bus.load_min, bus.load_sec}, 0);
    chk("rst_commit", bus.commit, 0);
    chk("rst_enable", bus.enable_sec, 0);
    chk("rst_data", {bus.data_hour, bus.data_min, bus.data_sec}, 0);
    for (int i = 0; i < 3; i++) begin
      bus.tick_1hz = 1'b1;
      chk("run_en_before", bus.enable_sec, 0);
      cyc();
      bus.tick_1hz = 1'b0;
      chk("run_en_after", bus.enable_sec, 1);
      chk("run_load", {bus.load_hour, bus.load_min, bus.load_sec}, 0);
      cyc();
      chk("run_en_drop", bus.enable_sec, 0);
    end
    bus.cur_hour = 5'd12;
    bus.cur_min = 6'd34;
    bus.cur_sec = 6'd56;
    press_mode();
    chk("sh_setting", bus.setting, 1);
    chk("sh_field", bus.field_sel, 1);
    chk("sh_hour", bus.data_hour, 12);
    chk("sh_min", bus.data_min, 34);
    chk("sh_sec", bus.data_sec, 56);
    chk("sh_load", {bus.load_hour, bus.load_min, bus.load_sec}, 3'b111);
    chk("sh_commit", bus.commit, 0);
    press_mode();
    chk("sm_field", bus.field_sel, 2);
    press_mode();
    chk("ss_field", bus.field_sel, 3);
    chk("ss_commit", bus.commit, 0);
    press_mode();
    chk("c4_commit", bus.commit, 0);
    bus.cur_hour = 5'd0;
    cyc();
    chk("c4_commit_gone", bus.commit, 0);
    bus.cur_hour = 5'd23;
    bus.cur_min = 6'd0;
    bus.cur_sec = 6'd58;
    press_mode();
    chk("wrap_h0", bus.data_hour, 23);
    press_inc();
    chk("wrap_h1", bus.data_hour, 0);
    press_inc();
    chk("wrap_h2", bus.data_hour, 1);
    press_mode();
    press_mode();
    chk("wrap_s0", bus.data_sec, 58);
    press_inc();
    chk("wrap_s1", bus.data_sec, 59);
    press_inc();
    chk("wrap_s2", bus.data_sec, 0);
    chk("wrap_min", bus.data_min, 0);
    bus.mode_btn = 1'b1;
    cyc();
    bus.mode_btn = 1'b0;
    chk("exit_commit", bus.commit, 1);
    chk("exit_load", {bus.load_hour, bus.load_min, bus.load_sec}, 3'b111);
    chk("exit_setting", bus.setting, 0);
    chk("exit_field", bus.field_sel, 0);
    chk("exit_hour", bus.data_hour, 1);
    cyc();
    chk("exit_commit_1cyc", bus.commit, 0);
    chk("exit_load_off", {bus.load_hour, bus.load_min, bus.load_sec}, 0);
    bus.cur_hour = 5'd5;
    bus.cur_min = 6'd6;
    bus.cur_sec = 6'd7;
    press_mode();
    bus.tick_1hz = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    chk("set_tick_dropped", bus.enable_sec, 0);
    cyc();
    for (int i = 1; i < 9; i++) tick();
    press_inc();
    chk("tmo_inc", bus.data_hour, 6);
    for (int i = 0; i < 9; i++) tick();
    chk("tmo_restart_setting", bus.setting, 1);
    chk("tmo_restart_commit", bus.commit, 0);
    tick();
    chk("tmo_setting", bus.setting, 0);
    chk("tmo_commit", bus.commit, 1);
    chk("tmo_hour", bus.data_hour, 6);
    cyc();
    chk("tmo_commit_1cyc", bus.commit, 0);
    bus.cur_hour = 5'd1;
    bus.cur_min = 6'd2;
    bus.cur_sec = 6'd3;
    bus.tick_1hz = 1'b1;
    bus.mode_btn = 1'b1;
    cyc();
    bus.tick_1hz = 1'b0;
    bus.mode_btn = 1'b0;
    chk("tick_exit_en", bus.enable_sec, 0);
    chk("tick_exit_field", bus.field_sel, 1);
    cyc();
    press_mode();
    chk("both_pre_min", bus.data_min, 2);
    bus.mode_btn = 1'b1;
    bus.inc_btn = 1'b1;
    cyc();
    bus.mode_btn = 1'b0;
    bus.inc_btn = 1'b0;
    cyc();
    chk("both_field", bus.field_sel, 3);
    chk("both_min", bus.data_min, 2);
    chk("both_sec", bus.data_sec, 3);
    press_inc();
    chk("both_sec_inc", bus.data_sec, 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_setting", bus.setting, 0);
    chk("mid_rst_commit", bus.commit, 0);
    chk("mid_rst_data", {bus.data_hour, bus.data_min, bus.data_sec}, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_rst_commit", bus.commit, 0);
    chk("post_rst_field", bus.field_sel, 0);
    chk("post_rst_load", {bus.load_hour, bus.load_min, bus.load_sec}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
